// File: rtl/wb_timeout.sv
// Wishbone bus watchdog: combinational pass-through with registered
// timeout FSM that aborts stalled cycles with an error termination.
module wb_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  output logic                    timeout_o,
  output logic [15:0]             timeout_count_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_ABORT  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam bit EN = (TIMEOUT != 0);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [15:0]   r_tcnt;
  logic          w_req;
  logic          w_term;
  logic          w_pass;
  logic          w_abort;
  logic          w_go;

  assign w_req   = wbm_cyc_i & wbm_stb_i;
  assign w_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_pass  = (r_state == S_IDLE) | (r_state == S_ACTIVE);
  assign w_abort = (r_state == S_ABORT);
  assign w_go    = w_req & ~w_term;

  // Next-state and stall-counter update
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (EN && w_go) begin
          w_next     = S_ACTIVE;
          w_cnt_next = CW'(1);
        end else begin
          w_cnt_next = '0;
        end
      end
      S_ACTIVE: begin
        if (!w_go) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == TMAX) begin
          w_next     = S_ABORT;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_ABORT: begin
        w_cnt_next = '0;
        w_next     = w_req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        w_cnt_next = '0;
        if (!wbm_stb_i || !wbm_cyc_i) w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // State, stall counter and saturating abort counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_ACTIVE && w_next == S_ABORT &&
          r_tcnt != 16'hFFFF)
        r_tcnt <= r_tcnt + 16'd1;
    end
  end

  // Bus paths: straight through unless aborting or holding off
  always_comb begin
    wbs_adr_o       = wbm_adr_i;
    wbs_dat_o       = wbm_dat_i;
    wbs_sel_o       = wbm_sel_i;
    wbs_we_o        = w_pass & wbm_we_i;
    wbs_stb_o       = w_pass & wbm_stb_i;
    wbs_cyc_o       = w_pass & wbm_cyc_i;
    wbm_dat_o       = w_pass ? wbs_dat_i : '0;
    wbm_ack_o       = w_pass & wbs_ack_i;
    wbm_rty_o       = w_pass & wbs_rty_i;
    wbm_err_o       = w_abort | (w_pass & wbs_err_i);
    timeout_o       = w_abort;
    timeout_count_o = r_tcnt;
  end

endmodule

// File: tb/tb_wb_timeout.sv
// Directed bench for wb_timeout: TIMEOUT=4 unit plus a TIMEOUT=0
// unit sharing the same stimulus.
module tb_wb_timeout;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr, m_dat, s_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_stb, m_cyc;
  logic        s_ack, s_err, s_rty;

  logic [31:0] a_mdat, a_sadr, a_sdat;
  logic [3:0]  a_ssel;
  logic        a_ack, a_err, a_rty, a_swe, a_sstb, a_scyc, a_to;
  logic [15:0] a_tc;

  logic [31:0] z_mdat, z_sadr, z_sdat;
  logic [3:0]  z_ssel;
  logic        z_ack, z_err, z_rty, z_swe, z_sstb, z_scyc, z_to;
  logic [15:0] z_tc;

  int ntest = 0;
  int nfail = 0;
  int zbad;
  logic [15:0] exp_tc;

  always #5 clk = ~clk;

  wb_timeout #(.TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(a_mdat),
    .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb),
    .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
    .wbm_cyc_i(m_cyc),
    .wbs_adr_o(a_sadr), .wbs_dat_i(s_dat), .wbs_dat_o(a_sdat),
    .wbs_we_o(a_swe), .wbs_sel_o(a_ssel), .wbs_stb_o(a_sstb),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .wbs_cyc_o(a_scyc),
    .timeout_o(a_to), .timeout_count_o(a_tc)
  );

  wb_timeout #(.TIMEOUT(0)) u_z (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(z_mdat),
    .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb),
    .wbm_ack_o(z_ack), .wbm_err_o(z_err), .wbm_rty_o(z_rty),
    .wbm_cyc_i(m_cyc),
    .wbs_adr_o(z_sadr), .wbs_dat_i(s_dat), .wbs_dat_o(z_sdat),
    .wbs_we_o(z_swe), .wbs_sel_o(z_ssel), .wbs_stb_o(z_sstb),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .wbs_cyc_o(z_scyc),
    .timeout_o(z_to), .timeout_count_o(z_tc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v);
    m_cyc = v;
    m_stb = v;
  endtask

  task automatic slv(input logic ack, input logic err,
                     input logic rty);
    s_ack = ack;
    s_err = err;
    s_rty = rty;
  endtask

  // stall one access to abort, drop it in the abort cycle
  task automatic do_abort(input logic [15:0] want);
    req(1'b1);
    repeat (5) step();
    #2;
    chk("sat_abort_err", a_err, 1'b1);
    req(1'b0);
    step();
    #2;
    chk("sat_count", a_tc, want);
    step();
  endtask

  initial begin
    rst = 1'b1;
    m_adr = 32'h0000_0100;
    m_dat = 32'hA5A5_5A5A;
    m_sel = 4'hF;
    m_we = 1'b1;
    s_dat = 32'h1234_5678;
    slv(1'b0, 1'b0, 1'b0);
    req(1'b1);
    exp_tc = 16'd0;
    #2;
    chk("rst_to", a_to, 1'b0);
    chk("rst_tc", a_tc, 16'd0);
    chk("rst_pass_stb", a_sstb, 1'b1);
    chk("rst_z_tc", z_tc, 16'd0);
    req(1'b0);
    step();
    rst = 1'b0;
    step();

    // slave acks in cycle 2
    req(1'b1);
    #2;
    chk("t1_adr", a_sadr, 32'h0000_0100);
    chk("t1_dat", a_sdat, 32'hA5A5_5A5A);
    chk("t1_we", a_swe, 1'b1);
    chk("t1_sel", a_ssel, 4'hF);
    step();
    step();
    slv(1'b1, 1'b0, 1'b0);
    #2;
    chk("t1_ack", a_ack, 1'b1);
    chk("t1_err", a_err, 1'b0);
    chk("t1_rdat", a_mdat, 32'h1234_5678);
    step();
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    #2;
    chk("t1_tc", a_tc, 16'd0);
    step();

    // silent slave: abort in cycle 5, then hold with late acks
    req(1'b1);
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c == 4) begin
        chk("t2_pre_err", a_err, 1'b0);
        chk("t2_pre_stb", a_sstb, 1'b1);
      end
      step();
    end
    #2;
    chk("t2_err", a_err, 1'b1);
    chk("t2_stb", a_sstb, 1'b0);
    chk("t2_cyc", a_scyc, 1'b0);
    chk("t2_to", a_to, 1'b1);
    chk("t2_rdat", a_mdat, 32'h0);
    chk("t2_z_err", z_err, 1'b0);
    chk("t2_z_stb", z_sstb, 1'b1);
    exp_tc = exp_tc + 16'd1;
    step();
    slv(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t2_hold_ack", a_ack, 1'b0);
      chk("t2_hold_err", a_err, 1'b0);
      chk("t2_hold_stb", a_sstb, 1'b0);
      step();
    end
    chk("t2_hold_to", a_to, 1'b0);
    chk("t2_tc", a_tc, exp_tc);
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    step();
    req(1'b1);
    slv(1'b1, 1'b0, 1'b0);
    #2;
    chk("t2_next_ack", a_ack, 1'b1);
    chk("t2_next_stb", a_sstb, 1'b1);
    step();
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    step();

    // ack exactly when the counter reaches TIMEOUT
    req(1'b1);
    repeat (4) step();
    slv(1'b1, 1'b0, 1'b0);
    #2;
    chk("t3_ack", a_ack, 1'b1);
    chk("t3_err", a_err, 1'b0);
    step();
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    #2;
    chk("t3_late_err", a_err, 1'b0);
    chk("t3_late_to", a_to, 1'b0);
    chk("t3_tc", a_tc, exp_tc);
    step();

    // cyc drop mid-stall restarts the count
    req(1'b1);
    repeat (3) step();
    m_cyc = 1'b0;
    #2;
    chk("t4_cyc_pass", a_scyc, 1'b0);
    step();
    req(1'b1);
    repeat (4) step();
    #2;
    chk("t4_no_early_err", a_err, 1'b0);
    step();
    #2;
    chk("t4_err", a_err, 1'b1);
    exp_tc = exp_tc + 16'd1;
    req(1'b0);
    step();
    #2;
    chk("t4_tc", a_tc, exp_tc);
    step();

    // err and rty pass through
    req(1'b1);
    slv(1'b0, 1'b1, 1'b0);
    #2;
    chk("t5_err", a_err, 1'b1);
    step();
    slv(1'b0, 1'b0, 1'b1);
    #2;
    chk("t5_rty", a_rty, 1'b1);
    chk("t5_rty_err", a_err, 1'b0);
    step();
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    step();

    // reset asserted mid-hold
    req(1'b1);
    repeat (6) step();
    #2;
    chk("t6_in_hold", a_sstb, 1'b0);
    slv(1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_stb", a_sstb, 1'b1);
    chk("t6_rst_ack", a_ack, 1'b1);
    chk("t6_rst_err", a_err, 1'b0);
    chk("t6_rst_tc", a_tc, 16'd0);
    chk("t6_rst_to", a_to, 1'b0);
    rst = 1'b0;
    exp_tc = 16'd0;
    req(1'b0);
    slv(1'b0, 1'b0, 1'b0);
    step();
    step();

    // TIMEOUT=0 unit never aborts
    zbad = 0;
    req(1'b1);
    for (int c = 0; c < 1000; c++) begin
      #2;
      if (z_err !== 1'b0 || z_to !== 1'b0 || z_sstb !== 1'b1)
        zbad++;
      step();
    end
    chk("t7_z_no_err", zbad, 0);
    chk("t7_z_tc", z_tc, 16'd0);
    exp_tc = exp_tc + 16'd1;
    req(1'b0);
    step();
    #2;
    chk("t7_a_tc", a_tc, exp_tc);
    step();

    // saturation near the top of the abort counter
    force u_a.r_tcnt = 16'hFFFD;
    step();
    release u_a.r_tcnt;
    step();
    #2;
    chk("t8_preset", a_tc, 16'hFFFD);
    step();
    do_abort(16'hFFFE);
    do_abort(16'hFFFF);
    do_abort(16'hFFFF);
    chk("t8_z_tc", z_tc, 16'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/wb_timeout.md
WB_TIMEOUT -- requirements
Module: wb_timeout

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, cycles without termination before abort; 0 disables abort.
REQ-005 Ports SHALL be, in order: clk in 1 clock; rst in 1 reset. Block uses one clock; reset is asynchronous and active-high.
REQ-006 Master side: wbm_adr_i in ADDR_WIDTH; wbm_dat_i in DATA_WIDTH; wbm_dat_o out DATA_WIDTH; wbm_we_i in 1; wbm_sel_i in SELECT_WIDTH; wbm_stb_i in 1; wbm_ack_o out 1; wbm_err_o out 1; wbm_rty_o out 1; wbm_cyc_i in 1.
REQ-007 Slave side, feeding the address-decode mux: wbs_adr_o out ADDR_WIDTH; wbs_dat_i in DATA_WIDTH; wbs_dat_o out DATA_WIDTH; wbs_we_o out 1; wbs_sel_o out SELECT_WIDTH; wbs_stb_o out 1; wbs_ack_i in 1; wbs_err_i in 1; wbs_rty_i in 1; wbs_cyc_o out 1.
REQ-008 Status: timeout_o out 1, one-cycle pulse per abort; timeout_count_o out 16, saturating abort count.

Function
REQ-009 States: IDLE, ACTIVE, ABORT, HOLD; state and counter registered; bus paths combinational, zero added latency.
REQ-010 IDLE/ACTIVE: wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o equal master inputs; wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o equal slave inputs.
REQ-011 term = wbs_ack_i | wbs_err_i | wbs_rty_i; req = wbm_cyc_i & wbm_stb_i.
REQ-012 IDLE -> ACTIVE when req & ~term; counter loads 1 on that edge.
REQ-013 ACTIVE: each cycle with req & ~term increments counter; term or ~req clears counter and returns to IDLE.
REQ-014 ACTIVE -> ABORT when counter == TIMEOUT and req & ~term in that cycle; abort error thus appears in cycle TIMEOUT+... precisely: stb rises in cycle 0, no term ever, wbm_err_o asserts in cycle TIMEOUT+1.
REQ-015 Term in the same cycle the counter reaches TIMEOUT wins: forwarded normally, no abort.
REQ-016 ABORT (exactly one cycle): wbm_err_o=1, wbm_ack_o=0, wbm_rty_o=0, wbm_dat_o=0, wbs_cyc_o=0, wbs_stb_o=0, wbs_we_o=0; timeout_o=1; timeout_count_o increments unless 16'hFFFF.
REQ-017 ABORT -> HOLD if req still high, else IDLE.
REQ-018 HOLD: slave strobes/cycle forced 0, all master terminations 0, late slave ack/err/rty discarded; -> IDLE on first cycle with ~wbm_stb_i or ~wbm_cyc_i.
REQ-019 wbm_cyc_i dropping in any state returns to IDLE next cycle with counter cleared.
REQ-020 TIMEOUT == 0: never leave IDLE/ACTIVE abort path; pure pass-through; timeout_o stays 0.
REQ-021 Counter width SHALL be clog2(TIMEOUT+1), minimum 1; no wrap possible.

Reset
REQ-022 On rst high, asynchronously: state IDLE, counter 0, timeout_o 0, timeout_count_o 0; combinational pass-through outputs follow inputs.
REQ-023 Reset mid-ABORT or mid-HOLD returns to pass-through immediately; no err emitted after rst.

Structure
REQ-024 State encoding local localparams; no shared package entries; no sub-module, single flat module.

Verification
REQ-025 TIMEOUT=4, slave acks cycle 2 -> wbm_ack_o cycle 2, no err, timeout_count_o=0.
REQ-026 TIMEOUT=4, slave silent -> wbm_err_o=1 in cycle 5 only, wbs_stb_o=0 from cycle 5, timeout_o pulse, timeout_count_o=1.
REQ-027 TIMEOUT=4, ack in cycle 4 (boundary) -> ack forwarded, no err, count 0.
REQ-028 After abort, master holds stb 3 cycles and slave acks late -> wbm_ack_o stays 0; stb low -> IDLE; next access passes normally.
REQ-029 rst asserted mid-HOLD -> state IDLE same cycle, counters 0; TIMEOUT=0 with silent slave for 1000 cycles -> no err.
REQ-030 65537 forced aborts -> timeout_count_o saturates at 16'hFFFF.
